// File: rtl/status_pkg.sv
// Shared definitions for the status register stage and the decode-side condition evaluator.
// Holds the flag bit positions, the status word width and the condition-code encoding.
package status_pkg;

  localparam int STATUS_W = 32;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code evaluator.
// Maps a 4-bit condition field and the N/Z/C/V flags to a pass/fail bit.
module cond_eval
  import status_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       pass_o
);

  always_comb begin
    pass_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = z_i;
      COND_NE: pass_o = !z_i;
      COND_CS: pass_o = c_i;
      COND_CC: pass_o = !c_i;
      COND_MI: pass_o = n_i;
      COND_PL: pass_o = !n_i;
      COND_VS: pass_o = v_i;
      COND_VC: pass_o = !v_i;
      COND_HI: pass_o = c_i && !z_i;
      COND_LS: pass_o = !c_i || z_i;
      COND_GE: pass_o = (n_i == v_i);
      COND_LT: pass_o = (n_i != v_i);
      COND_GT: pass_o = !z_i && (n_i == v_i);
      COND_LE: pass_o = z_i || (n_i != v_i);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_register.sv
// Architectural status register with a small saved-status stack for exception entry/return.
// The condition field is always evaluated against the committed (registered) flags.
module status_register
  import status_pkg::*;
#(
  parameter int SPSR_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [STATUS_W-1:0]               flags_in,
  input  logic                              flags_we,
  input  logic                              exc_enter,
  input  logic                              exc_return,
  input  logic [3:0]                        cond,
  output logic [STATUS_W-1:0]               flags_old,
  output logic                              cond_pass,
  output logic [STATUS_W-1:0]               spsr_top,
  output logic [$clog2(SPSR_DEPTH+1)-1:0]   spsr_depth,
  output logic                              stack_err
);

  localparam int DW = $clog2(SPSR_DEPTH + 1);

  logic [STATUS_W-1:0] flags_q, flags_d;
  logic [STATUS_W-1:0] stack_q [SPSR_DEPTH];
  logic [DW-1:0]       depth_q, depth_d;
  logic                err_q;

  logic [STATUS_W-1:0] nxt;
  logic [STATUS_W-1:0] top;
  logic                full, empty, push, pop, err_set;

  assign nxt   = flags_we ? flags_in : flags_q;
  assign full  = (depth_q == DW'(SPSR_DEPTH));
  assign empty = (depth_q == '0);

  // Only a lone request on a stack that can accept it moves the stack; anything else is an error.
  assign push    = exc_enter && !exc_return && !full;
  assign pop     = exc_return && !exc_enter && !empty;
  assign err_set = (exc_enter && exc_return)
                 || (exc_enter && !exc_return && full)
                 || (exc_return && !exc_enter && empty);

  always_comb begin
    top = '0;
    for (int i = 0; i < SPSR_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    flags_d = pop ? top : nxt;
    depth_d = depth_q;
    if (push)     depth_d = depth_q + DW'(1);
    else if (pop) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < SPSR_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_q || err_set;
      for (int i = 0; i < SPSR_DEPTH; i++) begin
        if (push && depth_q == DW'(i)) stack_q[i] <= nxt;
      end
    end
  end

  cond_eval u_cond_eval (
    .cond_i (cond),
    .n_i    (flags_q[N_BIT]),
    .z_i    (flags_q[Z_BIT]),
    .c_i    (flags_q[C_BIT]),
    .v_i    (flags_q[V_BIT]),
    .pass_o (cond_pass)
  );

  assign flags_old  = flags_q;
  assign spsr_top   = top;
  assign spsr_depth = depth_q;
  assign stack_err  = err_q;

endmodule

// File: tb/tb_status_register.sv
// Directed testbench for status_register: flag commit, condition codes, stack push/pop/errors
// and asynchronous reset, with hand-computed expected values.
module tb_status_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flags_in;
  logic        flags_we;
  logic        exc_enter;
  logic        exc_return;
  logic [3:0]  cond;
  logic [31:0] flags_old;
  logic        cond_pass;
  logic [31:0] spsr_top;
  logic [1:0]  spsr_depth;
  logic        stack_err;

  int checkCount = 0;
  int passCount  = 0;

  status_register #(.SPSR_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flags_in   (flags_in),
    .flags_we   (flags_we),
    .exc_enter  (exc_enter),
    .exc_return (exc_return),
    .cond       (cond),
    .flags_old  (flags_old),
    .cond_pass  (cond_pass),
    .spsr_top   (spsr_top),
    .spsr_depth (spsr_depth),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Drive one cycle of requests, then sample 1ns after the rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] fin, input logic enter, input logic ret);
    flags_we   = we;
    flags_in   = fin;
    exc_enter  = enter;
    exc_return = ret;
    @(posedge clk);
    #1;
    flags_we   = 1'b0;
    exc_enter  = 1'b0;
    exc_return = 1'b0;
  endtask

  task automatic checkCond(input string tag, input logic [3:0] c, input logic expected);
    cond = c;
    #1;
    checkOutput(tag, cond_pass, expected);
  endtask

  task automatic checkState(input string tag, input logic [31:0] fo, input logic [31:0] top,
                            input logic [1:0] depth, input logic err);
    checkOutput({tag, "_flags"}, flags_old, fo);
    checkOutput({tag, "_top"}, spsr_top, top);
    checkOutput({tag, "_depth"}, spsr_depth, depth);
    checkOutput({tag, "_err"}, stack_err, err);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Grouped by pairs: even code is the base predicate, odd code its complement.
  function automatic logic expectCond(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v, b;
    n  = nzcv[3];
    z  = nzcv[2];
    cf = nzcv[1];
    v  = nzcv[0];
    case (c[3:1])
      3'd0:    b = z;
      3'd1:    b = cf;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = cf & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  initial begin
    rst        = 1'b1;
    flags_in   = '0;
    flags_we   = 1'b0;
    exc_enter  = 1'b0;
    exc_return = 1'b0;
    cond       = 4'h0;
    #1;
    checkState("reset", 32'h0, 32'h0, 2'd0, 1'b0);
    checkCond("reset_EQ", 4'h0, 1'b0);
    checkCond("reset_NE", 4'h1, 1'b1);
    checkCond("reset_GE", 4'hA, 1'b1);
    checkCond("reset_HI", 4'h8, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 1'b0);
    checkOutput("write_Z", flags_old, 32'h4000_0000);
    checkCond("write_Z_EQ", 4'h0, 1'b1);
    checkCond("write_Z_NE", 4'h1, 1'b0);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("we_low_hold", flags_old, 32'h4000_0000);

    applyStimulus(1'b1, 32'h6000_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9000_0000, 1'b1, 1'b0);
    checkState("push1", 32'h9000_0000, 32'h9000_0000, 2'd1, 1'b0);
    checkCond("push1_LT", 4'hB, 1'b0);

    applyStimulus(1'b1, 32'hA000_0000, 1'b1, 1'b0);
    checkState("push2", 32'hA000_0000, 32'hA000_0000, 2'd2, 1'b0);
    applyStimulus(1'b1, 32'h3000_0000, 1'b1, 1'b0);
    checkState("overflow", 32'h3000_0000, 32'hA000_0000, 2'd2, 1'b1);

    #2;
    rst = 1'b1;
    #1;
    checkState("async_rst", 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 32'h2000_0000, 1'b1, 1'b0);
    checkState("push_c", 32'h2000_0000, 32'h2000_0000, 2'd1, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    checkState("write_n", 32'h8000_0000, 32'h2000_0000, 2'd1, 1'b0);
    applyStimulus(1'b1, 32'h1000_0000, 1'b0, 1'b1);
    checkState("pop", 32'h2000_0000, 32'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkState("underflow", 32'h2000_0000, 32'h0, 2'd0, 1'b1);
    applyStimulus(1'b1, 32'h7000_0000, 1'b0, 1'b1);
    checkState("underflow_we", 32'h7000_0000, 32'h0, 2'd0, 1'b1);

    resetDut();
    applyStimulus(1'b1, 32'h1111_0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h5000_0000, 1'b1, 1'b1);
    checkState("conflict", 32'h5000_0000, 32'h1111_0000, 2'd1, 1'b1);

    resetDut();
    applyStimulus(1'b1, 32'hC000_0001, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0F00_0000, 1'b0, 1'b1);
    checkState("push_pop", 32'hC000_0001, 32'h0, 2'd0, 1'b0);
    applyStimulus(1'b1, 32'h5555_0000, 1'b1, 1'b0);
    checkState("pop_push", 32'h5555_0000, 32'h5555_0000, 2'd1, 1'b0);

    for (int f = 0; f < 16; f++) begin
      logic [3:0]  nzcv;
      logic [31:0] word;
      nzcv = 4'(f);
      word = {nzcv, 28'h0ABC_DE0 + 28'(f)};
      applyStimulus(1'b1, word, 1'b0, 1'b0);
      checkOutput("sweep_flags", flags_old, word);
      for (int c = 0; c < 16; c++) begin
        checkCond($sformatf("sweep_c%0h_f%0h", c, f), 4'(c), expectCond(4'(c), nzcv));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/status_register.md
# status_register

Architectural status register stage directly downstream of the flag-update mux. Captures the merged 32-bit status word produced each cycle, feeds it back as the "old flags" input to the flag-update mux, and evaluates the 4-bit condition field of the next instruction against the committed N/Z/C/V bits. Also holds a small saved-status stack for exception entry and return.

## Interface

Parameters:
- SPSR_DEPTH, 2: number of saved-status slots (≥1); nesting deeper than this is an error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flags_in  in  32  merged status word from the flag-update mux.
- flags_we  in  1  commit flags_in to the status register this cycle.
- exc_enter  in  1  push the status word onto the saved-status stack.
- exc_return  in  1  pop the top saved word back into the status register.
- cond  in  4  condition field of the instruction in decode.
- flags_old  out  32  registered status word; fed back to the flag-update mux.
- cond_pass  out  1  combinational; cond evaluated against flags_old.
- spsr_top  out  32  top-of-stack saved word; 0 when the stack is empty.
- spsr_depth  out  $clog2(SPSR_DEPTH+1)  occupied slots.
- stack_err  out  1  sticky; set on overflow, underflow or a conflicting request.

## Operation

- Bit positions: N=31, Z=30, C=29, V=28. Bits 27:0 are stored and restored unchanged, with no interpretation.
- Next-status value `nxt`:
  - flags_in when flags_we=1;
  - otherwise flags_old.
- Request handling:
  - exc_enter only, stack not full: push `nxt`, depth+1, flags_old <= `nxt`.
  - exc_enter only, stack full: stack unchanged, flags_old <= `nxt`, stack_err <= 1.
  - exc_return only, stack not empty: flags_old <= popped word, depth-1. flags_we is ignored that cycle.
  - exc_return only, stack empty: flags_old <= `nxt`, stack_err <= 1.
  - exc_enter and exc_return together: stack unchanged, flags_old <= `nxt`, stack_err <= 1.
  - Neither request: flags_old <= `nxt`.
- stack_err clears only on rst.
- Condition codes for cond_pass:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.

## Timing

- Reset values: flags_old=0, all stack slots=0, spsr_depth=0, stack_err=0, spsr_top=0. Therefore cond_pass=1 for NE/CC/PL/VC/LS/GE/GT/AL immediately after reset.
- Reset is asynchronous: asserting rst mid-operation clears all state at once, including a push or pop in progress. No partial state survives.
- Write latency: 1 cycle. flags_in committed at edge k is visible on flags_old, and in cond_pass, from edge k onward.
- cond_pass uses registered flags only. There is no bypass of flags_in; hazard handling belongs to the pipeline control.
- Push/pop: spsr_top and spsr_depth update on the same edge as flags_old.
- Back-to-back push then pop on consecutive cycles is legal. So is a pop followed immediately by a push.

## Structure

- Shared package `status_pkg`:
  - flag bit-index constants (N_BIT=31, Z_BIT=30, C_BIT=29, V_BIT=28);
  - 4-bit condition encoding enum (COND_EQ … COND_NV);
  - status word width constant (32).
- One combinational sub-module, `cond_eval`, maps (cond, N, Z, C, V) to cond_pass. The decode stage reuses it.
- The stack is a register array plus a depth counter; no RAM macro is used.

## Test plan

- Reset, then flags_in=0x4000_0000 with flags_we=1; cond=0 (EQ) → cond_pass=1 after the edge. cond=1 (NE) → 0.
- flags_old=0x6000_0000, exc_enter with flags_we=1 and flags_in=0x9000_0000 → spsr_top=0x9000_0000, depth=1, flags_old=0x9000_0000. cond=B (LT) → 0.
- SPSR_DEPTH=2, three consecutive exc_enter → depth=2, stack_err=1 after the third push, spsr_top still the second pushed word.
- Push 0x2000_0000, write 0x8000_0000, then exc_return with flags_we=1 and flags_in=0x1000_0000 → flags_old=0x2000_0000, depth=0. Another exc_return → stack_err=1, flags_old unchanged.
- Assert rst asynchronously mid-cycle with depth=2 and stack_err=1 → all outputs 0 at once, without waiting for a clock edge.
- Sweep all 16 cond values across all 16 NZCV combinations → cond_pass matches the table above.
